// File: rtl/ca_sig_gen.sv
// GPS C/A code signal generator: G1/G2 Gold-code shift registers clocked by a
// code-rate NCO, with start-chip seek, epoch/bit-edge timing and data modulation.
module ca_sig_gen #(
   parameter int PHASE_W = 30
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [9:0]         prn_key,
   input  logic               prn_key_enable,
   input  logic [9:0]         start_chip,
   input  logic [PHASE_W-1:0] code_freq,
   input  logic               gen_enable,
   input  logic               data_bit,
   input  logic               data_valid,
   output logic               data_ready,
   output logic               chip_out,
   output logic               chip_enable,
   output logic               epoch,
   output logic               bit_edge,
   output logic [9:0]         chip_index,
   output logic               busy,
   output logic               data_underrun
);

   localparam logic [9:0] LAST_CHIP  = 10'd1022;
   localparam logic [4:0] LAST_EPOCH = 5'd19;

   typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

   state_t             state, state_nxt;
   logic [9:0]         g1, g2, g1_shift, g2_shift;
   logic [9:0]         start_lat, start_clamped;
   logic [PHASE_W-1:0] acc;
   logic [PHASE_W:0]   acc_sum;
   logic [4:0]         epoch_cnt;
   logic               cur_bit, underrun, seek_done;

   assign start_clamped = (start_chip > LAST_CHIP) ? LAST_CHIP : start_chip;
   assign acc_sum       = {1'b0, acc} + {1'b0, code_freq};
   assign seek_done     = (chip_index + 10'd1) == start_lat;
   assign g1_shift      = {g1[7] ^ g1[0], g1[9:1]};
   assign g2_shift      = {g2[8] ^ g2[7] ^ g2[4] ^ g2[2] ^ g2[1] ^ g2[0], g2[9:1]};

   assign busy          = (state != IDLE);
   assign chip_out      = busy & (g1[0] ^ g2[0] ^ cur_bit);
   assign data_underrun = underrun;

   // NOTE: flops are written with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Pulses are combinational so data_ready & data_valid is consumed on the same
   // edge that shifts the code and loads the new bit.
   always_comb begin
      // NOTE: every output gets a default first so no latch can be inferred.
      state_nxt   = state;
      chip_enable = 1'b0;
      epoch       = 1'b0;
      bit_edge    = 1'b0;
      data_ready  = 1'b0;
      if (prn_key_enable) begin
         state_nxt = (start_clamped != 10'd0) ? SEEK : RUN;
      end else begin
         case (state)
            SEEK: if (seek_done) state_nxt = RUN;
            RUN: begin
               chip_enable = gen_enable & acc_sum[PHASE_W];
               epoch       = chip_enable & (chip_index == LAST_CHIP);
               bit_edge    = epoch & (epoch_cnt == LAST_EPOCH);
               data_ready  = bit_edge;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         g1         <= '0;
         g2         <= '0;
         acc        <= '0;
         chip_index <= '0;
         epoch_cnt  <= '0;
         start_lat  <= '0;
         cur_bit    <= 1'b0;
         underrun   <= 1'b0;
      end else if (prn_key_enable) begin
         g1         <= 10'h3FF;
         g2         <= prn_key;
         acc        <= '0;
         chip_index <= '0;
         epoch_cnt  <= '0;
         start_lat  <= start_clamped;
         cur_bit    <= 1'b0;
         underrun   <= 1'b0;
      end else if (state == SEEK) begin
         g1         <= g1_shift;
         g2         <= g2_shift;
         chip_index <= chip_index + 10'd1;
      end else if ((state == RUN) && gen_enable) begin
         acc <= acc_sum[PHASE_W-1:0];
         if (chip_enable) begin
            g1         <= g1_shift;
            g2         <= g2_shift;
            chip_index <= epoch ? 10'd0 : chip_index + 10'd1;
            if (epoch) epoch_cnt <= bit_edge ? 5'd0 : epoch_cnt + 5'd1;
            if (bit_edge) begin
               if (data_valid) cur_bit  <= data_bit;
               else            underrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ca_sig_gen.sv
// Bench for ca_sig_gen: randomized stimulus, a table/arithmetic reference model
// predicting every cycle's outputs, and a monitor draining the expectation queue.
module tb_ca_sig_gen;

   localparam int W = 30;

   logic         clk = 1'b0, rstn = 1'b0;
   logic [9:0]   prn_key = '0, start_chip = '0;
   logic         prn_key_enable = 1'b0, gen_enable = 1'b0;
   logic [W-1:0] code_freq = '0;
   logic         data_bit = 1'b0, data_valid = 1'b0;
   logic         data_ready, chip_out, chip_enable, epoch, bit_edge, busy, data_underrun;
   logic [9:0]   chip_index;

   ca_sig_gen #(.PHASE_W(W)) dut (
      .clk(clk), .rstn(rstn), .prn_key(prn_key), .prn_key_enable(prn_key_enable),
      .start_chip(start_chip), .code_freq(code_freq), .gen_enable(gen_enable),
      .data_bit(data_bit), .data_valid(data_valid), .data_ready(data_ready),
      .chip_out(chip_out), .chip_enable(chip_enable), .epoch(epoch), .bit_edge(bit_edge),
      .chip_index(chip_index), .busy(busy), .data_underrun(data_underrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy, chip_out, chip_enable, epoch, bit_edge, data_ready, data_underrun;
      logic [9:0] chip_index;
   } obs_t;

   typedef enum {M_IDLE, M_SEEK, M_RUN} mst_t;

   obs_t exp_q[$];
   int   n_cmp = 0, n_bad = 0;

   // Reference model: one period of the code as a table, position as plain arithmetic.
   bit     code_tbl [1023];
   mst_t   m_st = M_IDLE;
   int     m_start = 0, m_seek = 0;
   longint m_total = 0;
   bit     m_bit = 0, m_und = 0;

   logic [9:0]   nxt_key = '0, nxt_start = '0;
   logic [W-1:0] nxt_freq = '0;

   task automatic build_code(input logic [9:0] key);
      logic [9:0] a, b;
      a = 10'h3FF;
      b = key;
      for (int i = 0; i < 1023; i++) begin
         code_tbl[i] = a[0] ^ b[0];
         a = {a[7] ^ a[0], a[9:1]};
         b = {b[8] ^ b[7] ^ b[4] ^ b[2] ^ b[1] ^ b[0], b[9:1]};
      end
   endtask

   task automatic step(input logic rst_v, input logic key_en, input logic gen_en,
                       input logic dv, input logic db);
      obs_t e;
      int   pos, idx, sc;
      bit   ev;
      @(posedge clk);
      #1;
      rstn = rst_v; prn_key_enable = key_en; gen_enable = gen_en;
      data_valid = dv; data_bit = db;
      prn_key = nxt_key; start_chip = nxt_start; code_freq = nxt_freq;
      e = '0;
      if (!rst_v) begin
         m_st = M_IDLE; m_start = 0; m_seek = 0; m_total = 0; m_bit = 0; m_und = 0;
      end else begin
         pos = (m_st == M_SEEK) ? m_seek : m_start + int'(m_total >> W);
         idx = pos % 1023;
         ev  = (m_st == M_RUN) && gen_en && !key_en &&
               (((m_total + longint'(code_freq)) >> W) != (m_total >> W));
         e.busy          = (m_st != M_IDLE);
         e.chip_index    = 10'(idx);
         e.chip_out      = e.busy & (code_tbl[idx] ^ m_bit);
         e.chip_enable   = ev;
         e.epoch         = ev && (idx == 1022);
         e.bit_edge      = e.epoch && ((((pos + 1) / 1023) % 20) == 0);
         e.data_ready    = e.bit_edge;
         e.data_underrun = m_und;
         if (key_en) begin
            sc      = (int'(start_chip) > 1022) ? 1022 : int'(start_chip);
            m_st    = (sc != 0) ? M_SEEK : M_RUN;
            m_start = sc; m_seek = 0; m_total = 0; m_bit = 0; m_und = 0;
            build_code(prn_key);
         end else if (m_st == M_SEEK) begin
            m_seek++;
            if (m_seek == m_start) m_st = M_RUN;
         end else if (m_st == M_RUN && gen_en) begin
            m_total += longint'(code_freq);
            if (e.bit_edge) begin
               if (dv) m_bit = db;
               else    m_und = 1;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: the DUT presents a full observation every cycle; sample mid-cycle.
   initial begin
      obs_t a, e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {busy, chip_out, chip_enable, epoch, bit_edge, data_ready, data_underrun, chip_index};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL obs @%0t: got busy=%b out=%b ce=%b ep=%b be=%b dr=%b und=%b idx=%0d | want busy=%b out=%b ce=%b ep=%b be=%b dr=%b und=%b idx=%0d",
                        $time, a.busy, a.chip_out, a.chip_enable, a.epoch, a.bit_edge, a.data_ready,
                        a.data_underrun, a.chip_index, e.busy, e.chip_out, e.chip_enable, e.epoch,
                        e.bit_edge, e.data_ready, e.data_underrun, e.chip_index);
            end
         end
      end
   end

   initial begin
      int n;
      // Reset and idle: everything zero, nothing leaves IDLE without a key pulse.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // PRN 1 (first chips 1100100000), no offset, one chip per two clocks.
      nxt_key = 10'h3EC; nxt_start = 10'd0; nxt_freq = W'(32'h2000_0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-RUN, then stay IDLE after release.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Seek to chip 5.
      nxt_start = 10'd5;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Out-of-range offset clamps to 1022, so the first chip produces an epoch.
      nxt_start = 10'd1023;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 1080; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Data 1 valid: run to the first bit edge with random rate/gating and a 100-clk hold.
      nxt_start = 10'd1000; nxt_freq = W'($urandom_range(32'h3FFF_FFFF, 32'h3000_0000));
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 40000 && !(m_bit && m_st == M_RUN); i++) begin
         if (i % 256 == 255) nxt_freq = W'($urandom_range(32'h3FFF_FFFF, 32'h3000_0000));
         step(1'b1, 1'b0, (i >= 200 && i < 300) ? 1'b0 : ($urandom_range(15, 0) != 0), 1'b1, 1'b1);
      end
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

      // No valid data at the next bit edge: sticky underrun, bit held.
      for (int i = 0; i < 40000 && !m_und; i++) begin
         if (i % 256 == 255) nxt_freq = W'($urandom_range(32'h3FFF_FFFF, 32'h3000_0000));
         step(1'b1, 1'b0, $urandom_range(15, 0) != 0, 1'b0, 1'($urandom));
      end
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // New random key and offset clear underrun and the current bit.
      nxt_key = 10'($urandom); nxt_start = 10'($urandom_range(1023, 0));
      nxt_freq = W'($urandom_range(32'h3FFF_FFFF, 32'h0100_0000));
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      n = int'(nxt_start) + 60;
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom));

      #20;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
